// File: rtl/cnn_pkg.sv
// cnn_pkg: shared defaults and FSM state encoding for the CNN classifier tail
package cnn_pkg;
  localparam int DEF_NUM_CLASSES = 10;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_IDX_W = 4;
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/argmax_update.sv
// argmax_update: signed strictly-greater compare/select of one score against the running best
module argmax_update import cnn_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic signed [DATA_W-1:0] i_best,
  input  logic        [IDX_W-1:0]  i_best_idx,
  input  logic signed [DATA_W-1:0] i_score,
  input  logic        [IDX_W-1:0]  i_cnt,
  output logic signed [DATA_W-1:0] o_next_best,
  output logic        [IDX_W-1:0]  o_next_idx
);
  logic w_gt;
  always_comb begin
    w_gt = i_score > i_best;
    o_next_best = w_gt ? i_score : i_best;
    o_next_idx = w_gt ? i_cnt : i_best_idx;
  end
endmodule

// File: rtl/argmax_stream_ctrl.sv
// argmax_stream_ctrl: running argmax over a beat-serial frame of class scores with result handshake
module argmax_stream_ctrl import cnn_pkg::*; #(
  parameter int NUM_CLASSES = DEF_NUM_CLASSES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     score_valid,
  output logic                     score_ready,
  input  logic signed [DATA_W-1:0] score_data,
  input  logic                     score_last,
  output logic                     result_valid,
  input  logic                     result_ready,
  output logic        [IDX_W-1:0]  result_index,
  output logic signed [DATA_W-1:0] result_score,
  output logic                     err_len,
  output logic        [15:0]       frame_count
);
  state_t r_state, w_state_nx;
  logic [IDX_W:0] r_cnt, w_cnt_nx;
  logic signed [DATA_W-1:0] r_best, w_best_nx;
  logic [IDX_W-1:0] r_idx, w_idx_nx;
  logic r_err;
  logic [15:0] r_frame_count;
  logic w_acc, w_full, w_end;
  argmax_update #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_upd (
    .i_best(r_best),
    .i_best_idx(r_idx),
    .i_score(score_data),
    .i_cnt(r_cnt[IDX_W-1:0]),
    .o_next_best(w_best_nx),
    .o_next_idx(w_idx_nx)
  );
  always_comb begin
    score_ready = !rst && r_state != DONE;
    w_acc = score_valid && score_ready;
    w_cnt_nx = r_state == IDLE ? (IDX_W+1)'(1) : r_cnt + 1'b1;
    w_full = w_cnt_nx == (IDX_W+1)'(NUM_CLASSES);
    w_end = w_acc && (score_last || w_full);
    w_state_nx = r_state == DONE ? (result_ready ? IDLE : DONE) : w_end ? DONE : w_acc ? ACCUM : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_best <= '0;
      r_idx <= '0;
      r_err <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state <= w_state_nx;
      r_err <= w_end && (score_last != w_full);
      if (w_acc) begin
        r_cnt <= w_cnt_nx;
        r_best <= r_state == IDLE ? score_data : w_best_nx;
        r_idx <= r_state == IDLE ? '0 : w_idx_nx;
      end
      if (r_state == DONE && result_ready) r_frame_count <= r_frame_count + 1'b1;
    end
  end
  always_comb begin
    result_valid = r_state == DONE;
    result_index = r_idx;
    result_score = r_best;
    err_len = r_err;
    frame_count = r_frame_count;
  end
endmodule

// File: tb/tb_argmax_stream_ctrl.sv
// tb_argmax_stream_ctrl: randomized and directed bench against a queue-based argmax model
module tb_argmax_stream_ctrl;
  localparam int N = 10;
  logic clk = 0, rst = 1, score_valid = 0, score_last = 0, result_ready = 0;
  logic signed [31:0] score_data = 0;
  logic score_ready, result_valid, err_len;
  logic [3:0] result_index;
  logic signed [31:0] result_score;
  logic [15:0] frame_count;
  logic signed [31:0] minv = 32'sh80000000;
  int vectors = 0, miscompares = 0;
  int q[$];
  bit m_pending = 0, m_err = 0;
  int m_idx = 0, m_score = 0;
  logic [15:0] m_fc = 0;
  int cyc = 0, err_cnt = 0;
  int hs[$];
  argmax_stream_ctrl dut (
    .clk(clk), .rst(rst), .score_valid(score_valid), .score_ready(score_ready),
    .score_data(score_data), .score_last(score_last), .result_valid(result_valid),
    .result_ready(result_ready), .result_index(result_index), .result_score(result_score),
    .err_len(err_len), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input longint a, input longint e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", n, a, e, cyc);
    end
  endtask
  always @(posedge clk) begin
    m_err = 0;
    if (rst) begin
      q.delete();
      m_pending = 0;
      m_fc = 0;
    end else if (m_pending) begin
      if (result_ready) begin
        m_pending = 0;
        m_fc = m_fc + 16'd1;
      end
    end else if (score_valid) begin
      q.push_back(score_data);
      if (score_last || q.size() == N) begin
        m_idx = 0;
        m_score = q[0];
        foreach (q[i]) if (q[i] > m_score) begin
          m_score = q[i];
          m_idx = i;
        end
        m_err = score_last != (q.size() == N);
        m_pending = 1;
        q.delete();
      end
    end
  end
  always @(negedge clk) begin
    cyc++;
    chk("score_ready", score_ready, !rst && !m_pending);
    chk("result_valid", result_valid, m_pending);
    chk("err_len", err_len, m_err);
    chk("frame_count", frame_count, m_fc);
    if (m_pending) begin
      chk("result_index", result_index, m_idx);
      chk("result_score", result_score, m_score);
    end
    if (err_len) err_cnt++;
    if (result_valid && result_ready) hs.push_back(cyc);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic signed [31:0] d, input logic l);
    int t = 0;
    score_valid = 1;
    score_data = d;
    score_last = l;
    while (!score_ready && t < 50) begin
      tick();
      t++;
    end
    chk("beat_accept_timeout", score_ready, 1);
    tick();
  endtask
  task automatic wait_valid();
    int t = 0;
    while (!result_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("result_valid_timeout", result_valid, 1);
  endtask
  int t1[N] = '{-5, 3, 9, 2, 9, 0, -1, 4, 8, 1};
  int t3[4] = '{1, 2, 7, 3};
  initial begin
    repeat (2) tick();
    chk("rst_ready", score_ready, 0);
    chk("rst_valid", result_valid, 0);
    chk("rst_index", result_index, 0);
    chk("rst_score", result_score, 0);
    chk("rst_err", err_len, 0);
    chk("rst_fc", frame_count, 0);
    rst = 0;
    tick();
    chk("idle_ready", score_ready, 1);
    result_ready = 1;
    err_cnt = 0;
    for (int i = 0; i < N; i++) beat(t1[i], i == N - 1);
    score_valid = 0;
    wait_valid();
    chk("t1_index", result_index, 2);
    chk("t1_score", result_score, 9);
    tick();
    chk("t1_fc", frame_count, 1);
    chk("t1_err", err_cnt, 0);
    for (int i = 0; i < N; i++) beat(minv, i == N - 1);
    score_valid = 0;
    wait_valid();
    chk("t2_index", result_index, 0);
    chk("t2_score", result_score, minv);
    tick();
    err_cnt = 0;
    for (int i = 0; i < 4; i++) beat(t3[i], i == 3);
    score_valid = 0;
    wait_valid();
    chk("t3_index", result_index, 2);
    chk("t3_score", result_score, 7);
    tick();
    chk("t3_err", err_cnt, 1);
    for (int i = 0; i < N; i++) beat(i * 5 - 20, i == N - 1);
    score_valid = 0;
    wait_valid();
    chk("t3b_index", result_index, 9);
    chk("t3b_score", result_score, 25);
    tick();
    chk("t3b_err", err_cnt, 1);
    result_ready = 0;
    for (int i = 0; i < N; i++) beat(i == 4 ? 50 : int'($urandom_range(0, 99)) - 60, i == N - 1);
    score_last = 0;
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_ready", score_ready, 0);
      chk("t4_index", result_index, 4);
      chk("t4_score", result_score, 50);
    end
    chk("t4_fc_hold", frame_count, 4);
    result_ready = 1;
    tick();
    chk("t4_fc", frame_count, 5);
    for (int i = 0; i < 6; i++) beat($urandom, 0);
    rst = 1;
    score_valid = 0;
    tick();
    chk("t5_ready", score_ready, 0);
    chk("t5_valid", result_valid, 0);
    chk("t5_index", result_index, 0);
    chk("t5_score", result_score, 0);
    chk("t5_fc", frame_count, 0);
    rst = 0;
    tick();
    for (int i = 0; i < N; i++) beat(i == 7 ? 100 : int'($urandom_range(0, 199)) - 100, i == N - 1);
    score_valid = 0;
    wait_valid();
    chk("t5_res_index", result_index, 7);
    chk("t5_res_score", result_score, 100);
    tick();
    chk("t5_res_fc", frame_count, 1);
    repeat (3000) begin
      score_valid = $urandom_range(0, 9) < 7;
      case ($urandom_range(0, 7))
        0: score_data = $urandom;
        1: score_data = minv;
        2: score_data = 32'sh7fffffff;
        default: score_data = int'($urandom_range(0, 15)) - 8;
      endcase
      score_last = $urandom_range(0, 11) == 0;
      result_ready = $urandom_range(0, 9) < 6;
      rst = $urandom_range(0, 199) == 0;
      tick();
    end
    rst = 1;
    score_valid = 0;
    result_ready = 0;
    tick();
    rst = 0;
    tick();
    force dut.r_frame_count = 16'hfffe;
    m_fc = 16'hfffe;
    tick();
    release dut.r_frame_count;
    tick();
    chk("t6_preset", frame_count, 16'hfffe);
    result_ready = 1;
    hs.delete();
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < N; i++) beat($urandom, i == N - 1);
    score_valid = 0;
    wait_valid();
    tick();
    tick();
    chk("t6_fc_wrap", frame_count, 1);
    chk("t6_results", hs.size(), 3);
    if (hs.size() == 3) begin
      chk("t6_period_a", hs[1] - hs[0], 11);
      chk("t6_period_b", hs[2] - hs[1], 11);
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/argmax_stream_ctrl.md
Name: argmax_stream_ctrl

Overview:
Sequences the final classification step of the CNN accelerator. The dense output layer emits its class scores one per beat rather than as ten parallel words. This block tracks the running maximum and its index across one frame of NUM_CLASSES scores. It then presents the winning digit and its score to the downstream consumer (result register / UART / LED driver) over a valid/ready handshake, and flags malformed frames.

Parameters:
NUM_CLASSES, 10, scores per frame (class count); legal range 2..16
DATA_W, 32, signed score width (two's complement)
IDX_W, 4, index width; must satisfy 2**IDX_W >= NUM_CLASSES

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
score_valid  in  1  upstream score beat valid
score_ready  out  1  block can accept a score beat
score_data  in  DATA_W  signed class score; class index is implied by beat order
score_last  in  1  marks the final beat of a frame
result_valid  out  1  classification result available
result_ready  in  1  downstream accepts result
result_index  out  IDX_W  index of the maximum score
result_score  out  DATA_W  maximum score value
err_len  out  1  one-cycle pulse when a frame is malformed
frame_count  out  16  number of results accepted downstream, wraps at 2**16

Behaviour:
- Interface decision: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: score_ready=0 during the rst cycle; then 1 on the following cycle (IDLE). result_valid=0, result_index=0, result_score=0, err_len=0, frame_count=0. State=IDLE, beat counter=0.
- Reset mid-frame or mid-result: the partial frame and any pending result are discarded; nothing is emitted.
- Beat acceptance: a beat transfers on a cycle where score_valid && score_ready.
- States:
  - IDLE: score_ready=1. On the first accepted beat: best<=score_data, best_idx<=0, cnt<=1, go to ACCUM. If that beat also ends the frame, go directly to DONE.
  - ACCUM: score_ready=1. On each accepted beat, compare score_data against best as signed values. If score_data is strictly greater, update best<=score_data and best_idx<=cnt. Then cnt<=cnt+1.
  - DONE: score_ready=0, result_valid=1. result_index and result_score hold stable until result_ready. On the handshake: frame_count++, then go to IDLE.
- Ties: the lowest index wins, because the comparison is strictly greater-than.
- Frame end: the frame ends on the accepted beat where score_last=1, or on the NUM_CLASSES-th accepted beat, whichever comes first.
- err_len: pulses high for 1 cycle, in the cycle after frame end, when score_last and the NUM_CLASSES-th beat do not coincide. This covers:
  - early last (last asserted before beat NUM_CLASSES);
  - missing last (beat NUM_CLASSES arrives without last).
  The result is still produced from the beats received. After a missing-last error, any further beats form the next frame.
- Latency: result_valid asserts the cycle after the final beat is accepted. A full frame takes NUM_CLASSES accepted beats + 1 cycle to result_valid. Minimum frame-to-frame period is NUM_CLASSES+1 cycles, assuming result_ready is held high.
- Backpressure: no beats are accepted in DONE. There is no bubble on the input side within a frame.
- Signed arithmetic: all score comparisons are signed. The most negative value is a legal score.
- Width rules: cnt is IDX_W+1 bits, so counting to NUM_CLASSES does not overflow. result_index is cnt truncated to IDX_W.

Decomposition:
- Shared package cnn_pkg holds:
  - NUM_CLASSES, DATA_W and IDX_W defaults;
  - the state enum (IDLE, ACCUM, DONE).
- One natural sub-module: argmax_update. It is a combinational signed compare/select that takes (best, best_idx, score, cnt) and returns (next_best, next_idx). It is reusable by a future parallel-tree variant.
- FSM and counters stay in the top module.

Test Plan:
1. Frame scores -5,3,9,2,9,0,-1,4,8,1 with last on beat 10, result_ready=1 -> result_index=2, result_score=9, err_len never asserts, frame_count=1.
2. All ten scores equal to 0x80000000 (most negative) -> result_index=0, result_score=0x80000000.
3. score_last on beat 4 with scores 1,2,7,3 -> err_len pulses once, result_index=2, result_score=7. Next full frame with maximum at index 9 -> result_index=9, no err_len.
4. Hold result_ready=0 for 5 cycles after result_valid while score_valid stays high -> score_ready=0 throughout and result outputs stable. Release result_ready -> frame_count increments and the next frame begins.
5. Assert rst after 6 beats of a frame -> all outputs return to reset values. A fresh frame with maximum 100 at index 7 -> result_index=7, result_score=100.
6. Back-to-back frames with result_ready=1 and score_valid=1 continuously -> one result every 11 cycles. frame_count counts correctly and wraps from 0xFFFF to 0 (force the counter near wrap).
